simd_seq_fetch: RTL and testbench

Parametrised instruction fetch and PE sequencer for the SIMD matrix processor, the next generation of the combined control/fetch unit. It prefetches 32-bit instructions from instruction memory into a small in-order buffer over a variable-latency request/response handshake. It decodes each instruction and drives lane-masked MAC, clear and write-back strobes plus A/B/C register-file sequence indices to N processing elements. It sits between the AXI-GPIO start/done pair and the PE array / register files.

---
 rtl/simd_seq_fetch_if.sv | 14 +
 rtl/simd_seq_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_simd_seq_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/simd_seq_fetch_if.sv
// Instruction-memory fetch bus between simd_seq_fetch (master) and instruction memory (slave).
interface simd_seq_fetch_if #(
  parameter int IADDR_W = 8
);
  // Handshake: imem_req is taken on every edge it is high (the memory never stalls);
  // each imem_rvalid pulse returns one imem_rdata word, in request order, >= 1 cycle later.
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic               imem_rvalid;
  logic [31:0]        imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/simd_seq_fetch.sv
// Instruction prefetch buffer plus PE sequencer for the SIMD matrix processor.
// Optional run/retire counters are built when SIMD_SEQ_PERF_CNT_EN is defined.
module simd_seq_fetch #(
  parameter int N        = 16,
  parameter int IADDR_W  = 8,
  parameter int DEPTH    = 4,
  parameter int START_PC = 0,
  localparam int LOGN    = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                done,
  simd_seq_fetch_if.master    imem,
  output logic [N-1:0]        mac_en,
  output logic [N-1:0]        mac_clr,
  output logic [N-1:0]        wr_en,
  output logic [LOGN-1:0]     seq_a,
  output logic [LOGN-1:0]     seq_b,
  output logic [LOGN-1:0]     seq_c,
  output logic [31:0]         cyc_cnt,
  output logic [31:0]         instr_cnt,
  output logic [1:0]          dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_MAC    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        buf_mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, outstanding, discard;
  logic [CW-1:0]      out_d, disc_d;
  logic [IADDR_W-1:0] pc;

  logic [LOGN-1:0]    k_q, k_d, k_last_q, k_last_d, row_q, row_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [N-1:0]       mac_en_d, mac_clr_d, wr_en_d;
  logic [LOGN-1:0]    seq_a_d, seq_b_d, seq_c_d;

  logic        active, req, pop, start_ok, halt_pop, flush, rsp, push;
  logic [31:0] head;
  logic [3:0]  op;
  logic [4:0]  k_field;
  logic        unused_head;

  assign head        = buf_mem[rd_ptr];
  assign op          = head[31:28];
  assign k_field     = {1'b0, head[19:16]};
  assign unused_head = ^head;

  assign active   = (state_q == S_RUN) || (state_q == S_MAC);
  // Gate on the pre-pop count so a same-cycle push can never overflow the buffer.
  assign req      = active && ((CW+1)'(count) + (CW+1)'(outstanding) < (CW+1)'(DEPTH));
  assign pop      = (state_q == S_RUN) && (count != '0);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_HALTED));
  assign halt_pop = pop && (op == 4'hF);
  assign flush    = halt_pop || (start_ok && (state_q == S_HALTED));
  assign rsp      = imem.imem_rvalid && (outstanding != '0);
  assign push     = rsp && (discard == '0) && !flush;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign done           = (state_q == S_HALTED);
  assign dbg_state      = state_q;

  // Words still in flight at a flush are tracked in discard and dropped as they land.
  always_comb begin
    out_d = outstanding;
    if (req) out_d = out_d + CW'(1);
    if (rsp) out_d = out_d - CW'(1);
    disc_d = discard;
    if (flush) disc_d = out_d;
    else if (rsp && (discard != '0)) disc_d = discard - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= imem.imem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      pc          <= IADDR_W'(START_PC);
    end else begin
      outstanding <= out_d;
      discard     <= disc_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (flush || start_ok) pc <= IADDR_W'(START_PC);
      else if (req)          pc <= pc + IADDR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    k_last_d  = k_last_q;
    row_d     = row_q;
    mask_d    = mask_q;
    mac_en_d  = '0;
    mac_clr_d = '0;
    wr_en_d   = '0;
    seq_a_d   = seq_a;
    seq_b_d   = seq_b;
    seq_c_d   = seq_c;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (pop) begin
          case (op)
            4'h1: begin
              state_d = S_MAC;
              k_d     = '0;
              row_d   = head[24 +: LOGN];
              mask_d  = head[N-1:0];
              // K = field + 1 clamped to N, so the last k index is min(field, N-1).
              if (k_field > 5'(N - 1)) k_last_d = LOGN'(N - 1);
              else                     k_last_d = k_field[LOGN-1:0];
            end
            4'h2: mac_clr_d = head[N-1:0];
            4'h3: begin
              wr_en_d = head[N-1:0];
              seq_c_d = head[24 +: LOGN];
            end
            4'hF: state_d = S_HALTED;
            default: ;
          endcase
        end
      end
      S_MAC: begin
        mac_en_d = mask_q;
        seq_a_d  = row_q;
        seq_b_d  = k_q;
        if (k_q == k_last_q) state_d = S_RUN;
        else                 k_d     = k_q + LOGN'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      k_last_q <= '0;
      row_q    <= '0;
      mask_q   <= '0;
      mac_en   <= '0;
      mac_clr  <= '0;
      wr_en    <= '0;
      seq_a    <= '0;
      seq_b    <= '0;
      seq_c    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      k_last_q <= k_last_d;
      row_q    <= row_d;
      mask_q   <= mask_d;
      mac_en   <= mac_en_d;
      mac_clr  <= mac_clr_d;
      wr_en    <= wr_en_d;
      seq_a    <= seq_a_d;
      seq_b    <= seq_b_d;
      seq_c    <= seq_c_d;
    end
  end

`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else if (start_ok) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (active) cyc_q   <= cyc_q + 32'd1;
      if (pop)    instr_q <= instr_q + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_simd_seq_fetch.sv
// Directed bench for simd_seq_fetch: N=16, 4-bit wrapping PC starting at 14, variable-latency memory.
module tb_simd_seq_fetch;
  localparam int N        = 16;
  localparam int IADDR_W  = 4;
  localparam int DEPTH    = 4;
  localparam int START_PC = 14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic          done;
  logic [N-1:0]  mac_en, mac_clr, wr_en;
  logic [3:0]    seq_a, seq_b, seq_c;
  logic [31:0]   cyc_cnt, instr_cnt;
  logic [1:0]    dbg_state;

  simd_seq_fetch_if #(.IADDR_W(IADDR_W)) imem ();

  simd_seq_fetch #(.N(N), .IADDR_W(IADDR_W), .DEPTH(DEPTH), .START_PC(START_PC)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .imem(imem),
    .mac_en(mac_en), .mac_clr(mac_clr), .wr_en(wr_en),
    .seq_a(seq_a), .seq_b(seq_b), .seq_c(seq_c),
    .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .dbg_state(dbg_state)
  );

  // ---------------- instruction memory model ----------------
  logic [31:0]        mem [16];
  int                 lat = 1;
  bit                 gap_en = 1'b0;
  int                 cyc = 0;
  int                 due_q[$];
  logic [IADDR_W-1:0] pend_q[$];
  logic [IADDR_W-1:0] addr_log[$];
  int                 max_inflight = 0;

  always @(negedge clk) begin
    cyc++;
    imem.imem_rvalid = 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc && !(gap_en && $urandom_range(0, 3) == 0)) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = mem[pend_q[0]];
      void'(due_q.pop_front());
      void'(pend_q.pop_front());
    end
    if (imem.imem_req && !rst) begin
      due_q.push_back(cyc + lat);
      pend_q.push_back(imem.imem_addr);
      addr_log.push_back(imem.imem_addr);
    end
    if (due_q.size() > max_inflight) max_inflight = due_q.size();
  end

  // ---------------- strobe monitor ----------------
  function automatic logic [29:0] ev(input logic [1:0] t, input logic [15:0] m,
                                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {t, m, a, b, c};
  endfunction

  logic [29:0] obs_q[$];
  int          run_cycles = 0;

  always @(negedge clk) begin
    if (mac_en  != '0) obs_q.push_back(ev(2'd1, mac_en, seq_a, seq_b, 4'd0));
    if (mac_clr != '0) obs_q.push_back(ev(2'd2, mac_clr, 4'd0, 4'd0, 4'd0));
    if (wr_en   != '0) obs_q.push_back(ev(2'd3, wr_en, 4'd0, 4'd0, seq_c));
    if (dbg_state == ST_RUN || dbg_state == 2'd2) run_cycles++;
  end

  // ---------------- scoreboard ----------------
  logic [29:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input bit main_prog);
    exp_q.delete();
    if (main_prog) begin
      exp_q.push_back(ev(2'd2, 16'hFFFF, 4'd0, 4'd0, 4'd0));
      for (int k = 0; k < 4; k++) exp_q.push_back(ev(2'd1, 16'h00FF, 4'd2, 4'(k), 4'd0));
      exp_q.push_back(ev(2'd3, 16'h00FF, 4'd0, 4'd0, 4'd2));
    end
  endtask

  task automatic load_main_prog();
    for (int i = 0; i < 16; i++) mem[i] = 32'h3100_0F0F;  // stray STOREs beyond HALT
    mem[14] = 32'h2000_FFFF;  // CLEAR  M=FFFF
    mem[15] = 32'h1203_00FF;  // MATMUL R=2 K=4 M=00FF
    mem[0]  = 32'h3200_00FF;  // STORE  R=2 M=00FF
    mem[1]  = 32'hF000_0000;  // HALT
  endtask

  // ---------------- driver: one program run ----------------
  task automatic run_prog(input string tag, input int latency, input bit gap,
                          input bit first_run, input int exp_instr);
    int obs_base, addr_base, run_base, n;
    logic [63:0] got;
    lat    = latency;
    gap_en = gap;
    @(negedge clk);
    obs_base  = obs_q.size();
    addr_base = addr_log.size();
    run_base  = run_cycles;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_low_after_start"}, 64'(done), 64'd0);
    check({tag, " state_run"}, 64'(dbg_state), 64'(ST_RUN));
    if (first_run) begin
      n = 0;
      while (mac_en == '0 && mac_clr == '0 && wr_en == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check({tag, " first_strobe_latency"}, 64'(n), 64'd3);
    end
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " state_halted"}, 64'(dbg_state), 64'(ST_HALTED));
    check({tag, " req_off_halted"}, 64'(imem.imem_req), 64'd0);
    check({tag, " event_count"}, 64'(obs_q.size() - obs_base), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      got = (obs_base + i < obs_q.size()) ? 64'(obs_q[obs_base + i]) : 64'h3FFF_FFFF;
      check({tag, " event"}, got, 64'(exp_q[i]));
    end
    if (first_run) begin
      for (int i = 0; i < 4; i++) begin
        got = (addr_base + i < addr_log.size()) ? 64'(addr_log[addr_base + i]) : 64'hFF;
        check({tag, " fetch_addr"}, got, 64'((START_PC + i) % 16));
      end
    end
`ifdef SIMD_SEQ_PERF_CNT_EN
    check({tag, " instr_cnt"}, 64'(instr_cnt), 64'(exp_instr));
    check({tag, " cyc_cnt"}, 64'(cyc_cnt), 64'(run_cycles - run_base));
`else
    check({tag, " instr_cnt_tied"}, 64'(instr_cnt), 64'd0);
    check({tag, " cyc_cnt_tied"}, 64'(cyc_cnt), 64'(exp_instr - exp_instr));
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    load_main_prog();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    check("reset done", 64'(done), 64'd0);
    check("reset req", 64'(imem.imem_req), 64'd0);
    check("reset addr", 64'(imem.imem_addr), 64'(START_PC));
    check("reset strobes", 64'({mac_en, mac_clr, wr_en}), 64'd0);
    check("reset seq", 64'({seq_a, seq_b, seq_c}), 64'd0);
    check("reset counters", {cyc_cnt, instr_cnt}, 64'd0);

    build_exp(1'b1);
    run_prog("run1_lat1", 1, 1'b0, 1'b1, 4);

    repeat (10) @(negedge clk);
    run_prog("run2_lat5_gap", 5, 1'b1, 1'b0, 4);

    run_prog("run3_lat3_restart", 3, 1'b0, 1'b0, 4);

    // Reset in the middle of a MATMUL with fetches still in flight.
    lat    = 4;
    gap_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mac_en != '0 && seq_b == 4'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst reached k2", 64'(seq_b), 64'd2);
    rst = 1'b1;
    #1;
    check("midrst strobes", 64'({mac_en, mac_clr, wr_en}), 64'd0);
    check("midrst seq", 64'({seq_a, seq_b, seq_c}), 64'd0);
    check("midrst state", 64'(dbg_state), 64'(ST_IDLE));
    check("midrst req", 64'(imem.imem_req), 64'd0);
    check("midrst addr", 64'(imem.imem_addr), 64'(START_PC));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = obs_q.size();
    repeat (20) @(negedge clk);
    check("postrst no strobes", 64'(obs_q.size() - n), 64'd0);
    check("postrst idle", 64'(dbg_state), 64'(ST_IDLE));
    check("postrst done", 64'(done), 64'd0);
    run_prog("run4_after_rst", 1, 1'b0, 1'b1, 4);

    // Unknown opcodes behave as NOPs: no strobes, still four retired instructions.
    mem[14] = 32'h5000_FFFF;
    mem[15] = 32'h0000_FFFF;
    mem[0]  = 32'hE123_FFFF;
    mem[1]  = 32'hF000_0000;
    build_exp(1'b0);
    repeat (10) @(negedge clk);
    run_prog("run5_nops", 2, 1'b0, 1'b0, 4);

    check("max inflight within depth", 64'(max_inflight <= DEPTH), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
